chip_trig_capture: RTL and testbench
====================================

// Module: chip_trig_capture
// PURPOSE
//  N-channel threshold-triggered frame capture; parametrised successor of the 8-channel chip selector.
//  Monitors N sample streams; on first sample >= threshold, locks to that channel.
//  Forwards cfg_len samples as one framed burst (sof/eof, channel id) to the downstream buffer.
//  Sits between the sample-matrix (sm) outputs and the chip buffer.
// PARAMETERS
//  N_CH  8   number of input channels (>=1)
//  DW    16  sample width, unsigned
//  LW    20  width of length/holdoff counters
//  PRE   4   pre-trigger depth in accepted beats (used only with CHIP_PRETRIG_EN, >=1)
//  CW    derived localparam = (N_CH>1) ? $clog2(N_CH) : 1
// PORTS
//  clk_sys        in   1        system clock
//  rst_n          in   1        async active-low reset
//  in_data        in   N_CH*DW  channel k at [k*DW +: DW]
//  in_vld         in   1        all channels valid together
//  in_rdy         out  1        = ~out_vld | out_rdy; beat accepted on in_vld & in_rdy
//  out_data       out  DW       selected sample
//  out_ch         out  CW       channel index of current frame
//  out_sof        out  1        first beat of frame
//  out_eof        out  1        last beat of frame
//  out_vld        out  1        output valid
//  out_rdy        in   1        downstream buffer ready
//  cfg_en         in   1        0: no new triggers; a frame in progress completes
//  cfg_th         in   DW       trigger threshold (unsigned >=)
//  cfg_len        in   LW       frame length in beats; 0 treated as 1
//  cfg_holdoff    in   LW       beats after eof during which triggers are ignored
//  cfg_rr         in   1        0 fixed priority (lowest index wins), 1 round-robin
//  stat_busy      out  1        state != IDLE
//  stat_trig_cnt  out  16       frames started, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state=IDLE; out_vld, out_sof, out_eof = 0; out_data, out_ch, stat_trig_cnt = 0; rr pointer = 0.
//  Output is a single registered stage: 1-cycle latency from an accepted beat to out_vld. Holds while out_vld & ~out_rdy.
//  All trigger, count and holdoff evaluation happens only on accepted beats. Nothing advances on idle or stalled cycles.
//  FSM:
//   IDLE    -> CAPTURE on accepted beat with cfg_en & any ch >= cfg_th.
//              Latch winning ch, cnt = max(cfg_len,1)-1. Trigger beat is emitted with sof=1 (eof=1 if len==1).
//   CAPTURE -> emits the locked channel each accepted beat, cnt--. eof on beat with cnt==0.
//              Then -> HOLDOFF if cfg_holdoff!=0, else IDLE.
//              New threshold crossings during CAPTURE are ignored.
//   HOLDOFF -> counts cfg_holdoff accepted beats, no output, then -> IDLE.
//              Eligible for a trigger on the beat after the last holdoff beat.
//  cfg_len and cfg_holdoff are sampled at frame start and holdoff start. Mid-frame changes do not affect the current frame.
//  cfg_rr/cfg_th changes take effect on the next IDLE evaluation.
//  Round-robin: search starts at (last winner+1) mod N_CH, wraps. Pointer updates only on a trigger.
//  Simultaneous crossings: exactly one winner per arbitration rule; the others are dropped silently.
//  Beats not in a frame are consumed (in_rdy follows output-stage rule) but not emitted.
//  stat_trig_cnt increments on each frame start.
// CONFIGURATION
//  CHIP_PRETRIG_EN defined:
//   per-channel PRE-deep delay line on accepted beats; trigger decided on live data.
//   Emitted data is taken from the delay line, so the frame starts PRE beats before the trigger sample.
//   Frame length is still cfg_len. Delay line resets to 0, so early frames carry zeros.
//  CHIP_PRETRIG_EN undefined: no delay line; the trigger sample is the first emitted beat. PRE is unused.
// STRUCTURE
//  Package chip_pkg: state enum (IDLE/CAPTURE/HOLDOFF), default DW/LW, clog2-based CW helper.
//  Sub-module chip_trig_arb:
//   input N_CH-bit hit vector, rr pointer, mode
//   output winner index + any_hit
//   combinational
// TESTING
//  N_CH=8, th=100, len=4, rr=0; ch3=150 at beat 0 -> 4 beats of ch3, sof on 1st, eof on 4th, out_ch=3, trig_cnt=1.
//  ch2 and ch5 both 200 on same beat, rr=1, ptr=3 -> ch5 wins. Repeat the same crossing after the frame -> ch2 wins.
//  len=3, holdoff=2; ch0 >= th on every beat -> 3 out, 2 gap, 3 out. Triggers inside capture do not extend the frame.
//  out_rdy=0 for 5 cycles mid-frame -> out_data/out_ch/out_eof stable, in_rdy=0, no beats lost or duplicated.
//  cfg_len=0 -> single-beat frame with sof=eof=1. Assert rst_n mid-frame -> all outputs 0, state IDLE, next crossing starts a fresh frame.
//  CHIP_PRETRIG_EN, PRE=2: ch1 ramp 0,10,..,150, th=100 -> frame starts with sample 80 (two beats before 100).

Source files
------------

// File: rtl/chip_pkg.sv
// Shared state encoding, default widths and channel-index width helper
// for the chip trigger-capture block.
package chip_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  localparam int DW_DEF = 16;
  localparam int LW_DEF = 20;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chip_trig_arb.sv
// Combinational channel arbiter: lowest hit index wins, or in round-robin
// mode the search starts just after the previous winner and wraps.
module chip_trig_arb
  import chip_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int CW   = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] hit_i,
  input  logic [CW-1:0]   ptr_i,
  input  logic            rr_i,
  output logic [CW-1:0]   win_o,
  output logic            any_hit_o
);

  int            start;
  logic [CW-1:0] idx;
  logic          found;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    start = rr_i ? (int'(ptr_i) + 1) % N_CH : 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = CW'((start + i) % N_CH);
      if (!found && hit_i[idx]) begin
        found = 1'b1;
        win_o = idx;
      end
    end
  end

  assign any_hit_o = |hit_i;

endmodule

// File: rtl/chip_trig_capture.sv
// Threshold-triggered frame capture over N_CH sample streams.
// Define CHIP_PRETRIG_EN to emit frames from a PRE-deep pre-trigger delay line.
module chip_trig_capture
  import chip_pkg::*;
#(
  parameter int  N_CH = 8,
  parameter int  DW   = DW_DEF,
  parameter int  LW   = LW_DEF,
  parameter int  PRE  = 4,
  localparam int CW   = ch_width(N_CH)
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic [N_CH*DW-1:0] in_data_i,
  input  logic               in_vld_i,
  output logic               in_rdy_o,
  output logic [DW-1:0]      out_data_o,
  output logic [CW-1:0]      out_ch_o,
  output logic               out_sof_o,
  output logic               out_eof_o,
  output logic               out_vld_o,
  input  logic               out_rdy_i,
  input  logic               cfg_en_i,
  input  logic [DW-1:0]      cfg_th_i,
  input  logic [LW-1:0]      cfg_len_i,
  input  logic [LW-1:0]      cfg_holdoff_i,
  input  logic               cfg_rr_i,
  output logic               stat_busy_o,
  output logic [15:0]        stat_trig_cnt_o
);

  if (N_CH < 1 || PRE < 1) begin : g_param_check
    $error("chip_trig_capture: N_CH and PRE must both be >= 1");
  end

  state_e        state_q;
  logic [LW-1:0] cnt_q;
  logic [CW-1:0] ch_q;
  logic [CW-1:0] rr_ptr_q;
  logic [DW-1:0] out_data_q;
  logic [CW-1:0] out_ch_q;
  logic          out_sof_q;
  logic          out_eof_q;
  logic          out_vld_q;
  logic [15:0]   trig_cnt_q;

  logic [DW-1:0]   live [N_CH];
  logic [N_CH-1:0] hit;
  logic [CW-1:0]   win;
  logic            any_hit;
  logic            accept;
  logic [CW-1:0]   sel_ch;
  logic [DW-1:0]   sel_data;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      live[k] = in_data_i[k*DW +: DW];
      hit[k]  = live[k] >= cfg_th_i;
    end
  end

  chip_trig_arb #(
    .N_CH (N_CH),
    .CW   (CW)
  ) u_arb (
    .hit_i     (hit),
    .ptr_i     (rr_ptr_q),
    .rr_i      (cfg_rr_i),
    .win_o     (win),
    .any_hit_o (any_hit)
  );

  assign in_rdy_o = ~out_vld_q | out_rdy_i;
  assign accept   = in_vld_i & in_rdy_o;
  assign sel_ch   = (state_q == IDLE) ? win : ch_q;

`ifdef CHIP_PRETRIG_EN
  // Trigger decisions use live data; emitted samples come PRE accepted beats late.
  logic [DW-1:0] dly_q [PRE][N_CH];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < PRE; p++) begin
        for (int k = 0; k < N_CH; k++) begin
          dly_q[p][k] <= '0;
        end
      end
    end else if (accept) begin
      for (int k = 0; k < N_CH; k++) begin
        dly_q[0][k] <= live[k];
        for (int p = 1; p < PRE; p++) begin
          dly_q[p][k] <= dly_q[p-1][k];
        end
      end
    end
  end

  assign sel_data = dly_q[PRE-1][sel_ch];
`else
  assign sel_data = live[sel_ch];
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      rr_ptr_q   <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      out_sof_q  <= 1'b0;
      out_eof_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      trig_cnt_q <= '0;
    end else if (accept) begin
      out_vld_q <= 1'b0;
      out_sof_q <= 1'b0;
      out_eof_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfg_en_i && any_hit) begin
            out_vld_q  <= 1'b1;
            out_sof_q  <= 1'b1;
            out_data_q <= sel_data;
            out_ch_q   <= win;
            ch_q       <= win;
            rr_ptr_q   <= win;
            if (trig_cnt_q != 16'hFFFF) trig_cnt_q <= trig_cnt_q + 16'd1;
            if (cfg_len_i > LW'(1)) begin
              state_q <= CAPTURE;
              cnt_q   <= cfg_len_i - LW'(1);
            end else begin
              out_eof_q <= 1'b1;
              state_q   <= (cfg_holdoff_i != '0) ? HOLDOFF : IDLE;
              cnt_q     <= cfg_holdoff_i;
            end
          end
        end
        CAPTURE: begin
          out_vld_q  <= 1'b1;
          out_data_q <= sel_data;
          out_ch_q   <= ch_q;
          // cnt_q holds the beats still owed after this one's predecessor.
          if (cnt_q == LW'(1)) begin
            out_eof_q <= 1'b1;
            state_q   <= (cfg_holdoff_i != '0) ? HOLDOFF : IDLE;
            cnt_q     <= cfg_holdoff_i;
          end else begin
            cnt_q <= cnt_q - LW'(1);
          end
        end
        HOLDOFF: begin
          if (cnt_q <= LW'(1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - LW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end else if (out_rdy_i) begin
      out_vld_q <= 1'b0;
      out_sof_q <= 1'b0;
      out_eof_q <= 1'b0;
    end
  end

  assign out_data_o      = out_data_q;
  assign out_ch_o        = out_ch_q;
  assign out_sof_o       = out_sof_q;
  assign out_eof_o       = out_eof_q;
  assign out_vld_o       = out_vld_q;
  assign stat_busy_o     = (state_q != IDLE);
  assign stat_trig_cnt_o = trig_cnt_q;

endmodule

// File: tb/tb_chip_trig_capture.sv
// Self-checking bench for chip_trig_capture: directed scenarios with random
// sample data, checked against a beat-level behavioural model.
module tb_chip_trig_capture;

  localparam int N   = 8;
  localparam int DW  = 16;
  localparam int LW  = 20;
  localparam int PRE = 2;
  localparam int CW  = 3;

  logic            clk_sys = 1'b0;
  logic            rst_n   = 1'b0;
  logic [N*DW-1:0] in_data;
  logic            in_vld;
  logic            in_rdy;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ch;
  logic            out_sof;
  logic            out_eof;
  logic            out_vld;
  logic            out_rdy;
  logic            cfg_en;
  logic [DW-1:0]   cfg_th;
  logic [LW-1:0]   cfg_len;
  logic [LW-1:0]   cfg_holdoff;
  logic            cfg_rr;
  logic            stat_busy;
  logic [15:0]     stat_trig_cnt;

  always #5 clk_sys = ~clk_sys;

  chip_trig_capture #(
    .N_CH (N),
    .DW   (DW),
    .LW   (LW),
    .PRE  (PRE)
  ) dut (
    .clk_sys         (clk_sys),
    .rst_n           (rst_n),
    .in_data_i       (in_data),
    .in_vld_i        (in_vld),
    .in_rdy_o        (in_rdy),
    .out_data_o      (out_data),
    .out_ch_o        (out_ch),
    .out_sof_o       (out_sof),
    .out_eof_o       (out_eof),
    .out_vld_o       (out_vld),
    .out_rdy_i       (out_rdy),
    .cfg_en_i        (cfg_en),
    .cfg_th_i        (cfg_th),
    .cfg_len_i       (cfg_len),
    .cfg_holdoff_i   (cfg_holdoff),
    .cfg_rr_i        (cfg_rr),
    .stat_busy_o     (stat_busy),
    .stat_trig_cnt_o (stat_trig_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frame/holdoff beats remaining, last winner, pending output.
  logic            mVld;
  logic [DW-1:0]   mData;
  logic [CW-1:0]   mCh;
  logic            mSof;
  logic            mEof;
  int              mRemain;
  int              mHold;
  int              mLast;
  int              mLocked;
  int              mTrig;
  logic [N*DW-1:0] hist [$];

  logic [N*DW-1:0] v;
  logic [9:0]      pat;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] chanOf(input logic [N*DW-1:0] d, input int k);
    return d[k*DW +: DW];
  endfunction

  function automatic logic [N*DW-1:0] randVec();
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'($urandom_range(0, 255));
    return r;
  endfunction

  function automatic logic [N*DW-1:0] lowVec();
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'($urandom_range(0, int'(cfg_th) - 1));
    return r;
  endfunction

  task automatic modelReset();
    mVld = 1'b0; mSof = 1'b0; mEof = 1'b0; mData = '0; mCh = '0;
    mRemain = 0; mHold = 0; mLast = 0; mLocked = 0; mTrig = 0;
    hist.delete();
  endtask

  task automatic modelBeat(input logic [N*DW-1:0] d);
    logic [N*DW-1:0] src;
    int w;
    int k;
    int len;
`ifdef CHIP_PRETRIG_EN
    src = (hist.size() >= PRE) ? hist[0] : '0;
`else
    src = d;
`endif
    hist.push_back(d);
    while (hist.size() > PRE) void'(hist.pop_front());
    mVld = 1'b0; mSof = 1'b0; mEof = 1'b0;
    if (mRemain > 0) begin
      mVld = 1'b1; mData = chanOf(src, mLocked); mCh = CW'(mLocked); mEof = (mRemain == 1);
      mRemain--;
      if (mRemain == 0) mHold = int'(cfg_holdoff);
    end else if (mHold > 0) begin
      mHold--;
    end else if (cfg_en) begin
      w = -1;
      for (int off = 0; off < N; off++) begin
        k = cfg_rr ? (mLast + 1 + off) % N : off;
        if (w < 0 && chanOf(d, k) >= cfg_th) w = k;
      end
      if (w >= 0) begin
        len = (cfg_len == 0) ? 1 : int'(cfg_len);
        mVld = 1'b1; mSof = 1'b1; mEof = (len == 1);
        mData = chanOf(src, w); mCh = CW'(w); mLocked = w; mLast = w;
        if (mTrig < 65535) mTrig++;
        mRemain = len - 1;
        if (mRemain == 0) mHold = int'(cfg_holdoff);
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("out_vld", out_vld, mVld);
    checkOutput("stat_busy", stat_busy, (mRemain > 0 || mHold > 0));
    checkOutput("stat_trig_cnt", stat_trig_cnt, mTrig);
    if (mVld) begin
      checkOutput("out_data", out_data, mData);
      checkOutput("out_ch", out_ch, mCh);
      checkOutput("out_sof", out_sof, mSof);
      checkOutput("out_eof", out_eof, mEof);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [N*DW-1:0] d, input logic rdy);
    logic expRdy;
    @(negedge clk_sys);
    in_vld  = vld;
    in_data = d;
    out_rdy = rdy;
    #1;
    expRdy = !mVld || rdy;
    checkOutput("in_rdy", in_rdy, expRdy);
    @(posedge clk_sys);
    if (vld && expRdy) modelBeat(d);
    else if (mVld && rdy) begin
      mVld = 1'b0; mSof = 1'b0; mEof = 1'b0;
    end
    #1;
    compareAll();
  endtask

  task automatic doReset();
    @(negedge clk_sys);
    rst_n  = 1'b0;
    in_vld = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_out_vld", out_vld, 0);
    checkOutput("rst_out_sof", out_sof, 0);
    checkOutput("rst_out_eof", out_eof, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_ch", out_ch, 0);
    checkOutput("rst_busy", stat_busy, 0);
    checkOutput("rst_trig_cnt", stat_trig_cnt, 0);
    @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  task automatic drainIdle();
    for (int i = 0; i < 40 && (mRemain > 0 || mHold > 0 || mVld); i++) applyStimulus(1'b1, lowVec(), 1'b1);
    checkOutput("drain_busy", stat_busy, 0);
  endtask

  initial begin
    in_vld = 1'b0; in_data = '0; out_rdy = 1'b1;
    cfg_en = 1'b1; cfg_th = 16'd100; cfg_len = 20'd4; cfg_holdoff = '0; cfg_rr = 1'b0;
    modelReset();
    doReset();

    $display("[TB] fixed priority, ch3 crossing");
    v = lowVec();
    v[3*DW +: DW] = 16'd150;
    applyStimulus(1'b1, v, 1'b1);
    checkOutput("s1_ch", out_ch, 3);
    checkOutput("s1_sof", out_sof, 1);
`ifndef CHIP_PRETRIG_EN
    checkOutput("s1_data", out_data, 150);
`endif
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, randVec(), 1'b1);
    checkOutput("s1_eof", out_eof, 1);
    checkOutput("s1_ch_end", out_ch, 3);
    checkOutput("s1_trig_cnt", stat_trig_cnt, 1);
    drainIdle();

    $display("[TB] round robin from pointer 3");
    cfg_rr = 1'b1;
    v = lowVec();
    v[2*DW +: DW] = 16'd200;
    v[5*DW +: DW] = 16'd200;
    applyStimulus(1'b1, v, 1'b1);
    checkOutput("s2_first_ch", out_ch, 5);
    drainIdle();
    applyStimulus(1'b1, v, 1'b1);
    checkOutput("s2_second_ch", out_ch, 2);
    checkOutput("s2_sof", out_sof, 1);
    drainIdle();

    $display("[TB] len 3, holdoff 2, ch0 always above threshold");
    cfg_rr = 1'b0; cfg_len = 20'd3; cfg_holdoff = 20'd2;
    pat = 10'b1110011100;
    for (int i = 0; i < 10; i++) begin
      v = randVec();
      v[0 +: DW] = DW'($urandom_range(100, 255));
      applyStimulus(1'b1, v, 1'b1);
      checkOutput("s3_vld_pattern", out_vld, pat[9-i]);
    end
    cfg_holdoff = '0;
    drainIdle();

    $display("[TB] backpressure mid-frame");
    cfg_len = 20'd6;
    v = lowVec();
    v[7*DW +: DW] = 16'd250;
    applyStimulus(1'b1, v, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, randVec(), 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, randVec(), 1'b0);
      checkOutput("s4_stall_in_rdy", in_rdy, 0);
      checkOutput("s4_stall_eof", out_eof, 0);
    end
    drainIdle();

    $display("[TB] zero length frame");
    cfg_len = '0;
    v = lowVec();
    v[4*DW +: DW] = 16'd120;
    applyStimulus(1'b1, v, 1'b1);
    checkOutput("s5_sof", out_sof, 1);
    checkOutput("s5_eof", out_eof, 1);
    checkOutput("s5_ch", out_ch, 4);
    applyStimulus(1'b1, lowVec(), 1'b1);
    checkOutput("s5_single", out_vld, 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) begin
        cfg_len     = LW'($urandom_range(0, 5));
        cfg_holdoff = LW'($urandom_range(0, 3));
        cfg_rr      = ($urandom_range(0, 1) == 1);
        cfg_en      = ($urandom_range(0, 7) != 0);
        cfg_th      = DW'($urandom_range(80, 200));
      end
      applyStimulus(($urandom_range(0, 9) < 8), randVec(), ($urandom_range(0, 3) != 0));
    end
    cfg_en = 1'b1; cfg_th = 16'd100; cfg_rr = 1'b0; cfg_holdoff = '0;
    drainIdle();

    $display("[TB] reset in the middle of a frame");
    cfg_len = 20'd5;
    v = lowVec();
    v[1*DW +: DW] = 16'd140;
    applyStimulus(1'b1, v, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, randVec(), 1'b1);
    doReset();
    v = lowVec();
    v[6*DW +: DW] = 16'd130;
    applyStimulus(1'b1, v, 1'b1);
    checkOutput("s7_ch", out_ch, 6);
    checkOutput("s7_sof", out_sof, 1);
    checkOutput("s7_trig_cnt", stat_trig_cnt, 1);
    drainIdle();

`ifdef CHIP_PRETRIG_EN
    $display("[TB] pre-trigger ramp on ch1");
    doReset();
    cfg_len = 20'd3;
    for (int i = 0; i < 16; i++) begin
      v = '0;
      v[1*DW +: DW] = DW'(10 * i);
      applyStimulus(1'b1, v, 1'b1);
      if (i == 10) begin
        checkOutput("s8_pre_data", out_data, 80);
        checkOutput("s8_pre_sof", out_sof, 1);
      end
    end
    drainIdle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
